// File: rtl/lsu_pkg.sv
// Shared constants, state type and request classification helpers for the load/store unit.
// Encodings follow the funct3 size/sign field, reused directly as the memory mask code.
package lsu_pkg;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} lsu_state_t;

  function automatic logic is_illegal(logic is_load, logic is_store, logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
           (is_store && funct3[2]) || (is_load == is_store);
  endfunction

  function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
           ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response/memory-port bundle between the MEM stage, the load/store unit and data memory.
// slave is the unit's view; master is the surrounding pipeline and memory.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_mask;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_data, resp_rd, resp_err,
    output mem_addr, mem_wdata, mem_mask, mem_rd_en, mem_wr_en,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_data, resp_rd, resp_err,
    input  mem_addr, mem_wdata, mem_mask, mem_rd_en, mem_wr_en,
    output mem_rdata
  );

endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of a loaded value according to funct3; purely combinational.
// Idempotent on data the memory has already extended, so aligned and split paths share it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (funct3)
      MASK_B:  result = {{24{raw[7]}}, raw[7:0]};
      MASK_BU: result = {24'h0, raw[7:0]};
      MASK_H:  result = {{16{raw[15]}}, raw[15:0]};
      MASK_HU: result = {16'h0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store initiator: aligned access in one memory cycle, misaligned split into bytes.
// Latency: aligned 2, split N+1, illegal 1 cycle; req_ready only in IDLE, response consumer never stalls.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  lsu_state_t  state, state_nxt;
  logic        is_load_q;
  logic        err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [1:0]  k_q;
  logic [31:0] asm_q;
  logic [31:0] ext_data;

  logic accept;
  logic req_illegal;
  logic req_misaligned;
  logic last_byte;

  assign accept         = bus.req_valid && (state == IDLE);
  assign req_illegal    = is_illegal(bus.req_is_load, bus.req_is_store, bus.req_funct3);
  assign req_misaligned = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  // Word splits run four byte beats, halfword splits two.
  assign last_byte      = (k_q == (funct3_q[1] ? 2'd3 : 2'd1));

  load_extend u_load_extend (
    .raw    (asm_q),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      k_q       <= '0;
      asm_q     <= '0;
    end else if (accept) begin
      is_load_q <= bus.req_is_load;
      err_q     <= req_illegal;
      funct3_q  <= bus.req_funct3;
      addr_q    <= bus.req_addr;
      wdata_q   <= bus.req_wdata;
      rd_q      <= bus.req_rd;
      k_q       <= '0;
      asm_q     <= '0;
    end else if (state == ACCESS) begin
      if (is_load_q) asm_q <= bus.mem_rdata;
    end else if (state == SPLIT) begin
      k_q <= k_q + 2'd1;
      if (is_load_q) asm_q[{k_q, 3'b000} +: 8] <= bus.mem_rdata[7:0];
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.resp_rd    = '0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_mask   = '0;
    bus.mem_rd_en  = 1'b0;
    bus.mem_wr_en  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (req_illegal)         state_nxt = RESP;
          else if (req_misaligned) state_nxt = SPLIT;
          else                     state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt     = RESP;
        bus.mem_addr  = addr_q;
        bus.mem_mask  = funct3_q;
        bus.mem_rd_en = is_load_q;
        bus.mem_wr_en = !is_load_q;
        bus.mem_wdata = is_load_q ? 32'h0 : wdata_q;
      end
      SPLIT: begin
        if (last_byte) state_nxt = RESP;
        bus.mem_addr  = addr_q + {30'h0, k_q};
        bus.mem_mask  = is_load_q ? MASK_BU : MASK_B;
        bus.mem_rd_en = is_load_q;
        bus.mem_wr_en = !is_load_q;
        bus.mem_wdata = is_load_q ? 32'h0 : {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
      end
      RESP: begin
        state_nxt      = IDLE;
        bus.resp_valid = 1'b1;
        bus.resp_rd    = rd_q;
        bus.resp_err   = err_q;
        bus.resp_data  = (is_load_q && !err_q) ? ext_data : 32'h0;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model plus a byte-level reference of what memory should hold.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0]  mem     [256] = '{default: 8'h00};
  logic [7:0]  ref_mem [256] = '{default: 8'h00};
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] seen_addr [$];
  longint      acc_time;
  int          total = 0;
  int          bad   = 0;

  // Memory device: combinational read sized by mask, byte-lane writes on the falling edge.
  assign b0 = mem[bus.mem_addr[7:0]];
  assign b1 = mem[bus.mem_addr[7:0] + 8'd1];
  assign b2 = mem[bus.mem_addr[7:0] + 8'd2];
  assign b3 = mem[bus.mem_addr[7:0] + 8'd3];

  always_comb begin
    bus.mem_rdata = 32'h0;
    if (bus.mem_rd_en) begin
      case (bus.mem_mask)
        3'b000:  bus.mem_rdata = {{24{b0[7]}}, b0};
        3'b001:  bus.mem_rdata = {{16{b1[7]}}, b1, b0};
        3'b010:  bus.mem_rdata = {b3, b2, b1, b0};
        3'b100:  bus.mem_rdata = {24'h0, b0};
        3'b101:  bus.mem_rdata = {16'h0, b1, b0};
        default: bus.mem_rdata = 32'h0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata[7:0];
      if (bus.mem_mask[1:0] != 2'b00) mem[bus.mem_addr[7:0] + 8'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_mask[1:0] == 2'b10) begin
        mem[bus.mem_addr[7:0] + 8'd2] <= bus.mem_wdata[23:16];
        mem[bus.mem_addr[7:0] + 8'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  // Reference rules: legal codes, access size, little-endian byte gather with arithmetic sign extension.
  function automatic logic ref_illegal(logic ld, logic st, logic [2:0] f3);
    return (ld == st) || !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (st && f3[2]);
  endfunction

  function automatic int ref_size(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] f3);
    longint v;
    int     n;
    n = ref_size(f3);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[8'(a + 32'(i))]) << (8 * i));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    for (int i = 0; i < ref_size(f3); i++) ref_mem[8'(a + 32'(i))] = d[8 * i +: 8];
  endtask

  // Issue one request and observe it to completion (bounded); lat stays -1 if no response appears.
  task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic [4:0] rrd, output int n_rd, output int n_wr);
    seen_addr.delete();
    lat = -1; rdata = 32'h0; err = 1'b0; rrd = 5'h0; n_rd = 0; n_wr = 0;
    @(negedge clk);
    for (int w = 0; w < 20 && !bus.req_ready; w++) @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_load  = ld;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.req_rd       = rd;
    @(posedge clk);
    acc_time = longint'($time);
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.mem_rd_en) n_rd++;
      if (bus.mem_wr_en) n_wr++;
      if (bus.mem_rd_en || bus.mem_wr_en) seen_addr.push_back(bus.mem_addr);
      if (bus.resp_valid) begin
        lat = c; rdata = bus.resp_data; err = bus.resp_err; rrd = bus.resp_rd;
        break;
      end
      @(posedge clk);
    end
    if (lat > 0 && st && !ref_illegal(ld, st, f3)) ref_store(a, f3, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'h0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'h0;
    repeat (3) @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
    total++; if ({bus.resp_valid, bus.resp_err, bus.mem_rd_en, bus.mem_wr_en} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {bus.resp_valid, bus.resp_err, bus.mem_rd_en, bus.mem_wr_en});
    end
    total++; if ({bus.resp_data, bus.resp_rd, bus.mem_addr, bus.mem_wdata, bus.mem_mask} !== '0) begin
      bad++; $display("FAIL reset_buses got=%h/%h/%h/%h/%h want=0", bus.resp_data, bus.resp_rd, bus.mem_addr, bus.mem_wdata, bus.mem_mask);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", bus.req_ready); end
  endtask

  task automatic test_aligned();
    int lat, nr, nw; logic [31:0] d; logic e; logic [4:0] r;
    do_req(1'b0, 1'b1, MASK_W, 32'h10, 32'hDEADBEEF, 5'd3, lat, d, e, r, nr, nw);
    total++; if (lat != 2 || nw != 1 || nr != 0) begin bad++; $display("FAIL sw_aligned lat=%0d wr=%0d rd=%0d want 2/1/0", lat, nw, nr); end
    total++; if (d !== 32'h0 || e !== 1'b0 || r !== 5'd3) begin bad++; $display("FAIL sw_resp data=%h err=%b rd=%0d want 0/0/3", d, e, r); end
    do_req(1'b1, 1'b0, MASK_W, 32'h10, 32'h0, 5'd4, lat, d, e, r, nr, nw);
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", d); end
    total++; if (lat != 2 || nr != 1 || nw != 0 || r !== 5'd4) begin bad++; $display("FAIL lw_timing lat=%0d rd_en=%0d wr_en=%0d tag=%0d want 2/1/0/4", lat, nr, nw, r); end
  endtask

  task automatic test_extend();
    int lat, nr, nw; logic [31:0] d; logic e; logic [4:0] r;
    do_req(1'b0, 1'b1, MASK_W, 32'h10, 32'h80FF7F01, 5'd1, lat, d, e, r, nr, nw);
    do_req(1'b1, 1'b0, MASK_B, 32'h13, 32'h0, 5'd2, lat, d, e, r, nr, nw);
    total++; if (d !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h want=ffffff80", d); end
    do_req(1'b1, 1'b0, MASK_BU, 32'h13, 32'h0, 5'd2, lat, d, e, r, nr, nw);
    total++; if (d !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h want=00000080", d); end
    do_req(1'b1, 1'b0, MASK_H, 32'h12, 32'h0, 5'd2, lat, d, e, r, nr, nw);
    total++; if (d !== 32'hFFFF80FF || lat != 2) begin bad++; $display("FAIL lh got=%h lat=%0d want=ffff80ff lat 2", d, lat); end
  endtask

  task automatic test_split_load();
    int lat, nr, nw; logic [31:0] d; logic e; logic [4:0] r;
    logic [31:0] want_addr [4] = '{32'h11, 32'h12, 32'h13, 32'h14};
    logic ok;
    do_req(1'b0, 1'b1, MASK_W, 32'h10, 32'h44332211, 5'd1, lat, d, e, r, nr, nw);
    do_req(1'b0, 1'b1, MASK_W, 32'h14, 32'h88776655, 5'd1, lat, d, e, r, nr, nw);
    do_req(1'b1, 1'b0, MASK_W, 32'h11, 32'h0, 5'd9, lat, d, e, r, nr, nw);
    total++; if (d !== 32'h55443322) begin bad++; $display("FAIL split_lw_data got=%h want=55443322", d); end
    total++; if (lat != 5 || nr != 4) begin bad++; $display("FAIL split_lw_timing lat=%0d rd_en=%0d want 5/4", lat, nr); end
    ok = (seen_addr.size() == 4);
    for (int i = 0; i < 4 && ok; i++) if (seen_addr[i] !== want_addr[i]) ok = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL split_lw_addrs count=%0d want 11,12,13,14", seen_addr.size()); end
  endtask

  task automatic test_split_store();
    int lat, nr, nw; logic [31:0] d; logic e; logic [4:0] r;
    do_req(1'b0, 1'b1, MASK_W, 32'h10, 32'h0, 5'd1, lat, d, e, r, nr, nw);
    do_req(1'b0, 1'b1, MASK_W, 32'h14, 32'h0, 5'd1, lat, d, e, r, nr, nw);
    do_req(1'b0, 1'b1, MASK_H, 32'h13, 32'h0000A1B2, 5'd6, lat, d, e, r, nr, nw);
    total++; if (nw != 2 || lat != 3) begin bad++; $display("FAIL split_sh wr_en=%0d lat=%0d want 2/3", nw, lat); end
    do_req(1'b1, 1'b0, MASK_W, 32'h10, 32'h0, 5'd1, lat, d, e, r, nr, nw);
    total++; if (d !== 32'hB2000000) begin bad++; $display("FAIL split_sh_lo got=%h want=b2000000", d); end
    do_req(1'b1, 1'b0, MASK_W, 32'h14, 32'h0, 5'd1, lat, d, e, r, nr, nw);
    total++; if (d !== 32'h000000A1) begin bad++; $display("FAIL split_sh_hi got=%h want=000000a1", d); end
  endtask

  task automatic test_illegal();
    int lat, nr, nw; logic [31:0] d; logic e; logic [4:0] r;
    do_req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 5'd12, lat, d, e, r, nr, nw);
    total++; if (e !== 1'b1 || d !== 32'h0 || r !== 5'd12) begin bad++; $display("FAIL illegal_f3 err=%b data=%h tag=%0d want 1/0/12", e, d, r); end
    total++; if (lat != 1 || nr != 0 || nw != 0) begin bad++; $display("FAIL illegal_f3_timing lat=%0d rd_en=%0d wr_en=%0d want 1/0/0", lat, nr, nw); end
    do_req(1'b0, 1'b1, MASK_BU, 32'h10, 32'hFFFFFFFF, 5'd13, lat, d, e, r, nr, nw);
    total++; if (e !== 1'b1 || nw != 0 || lat != 1) begin bad++; $display("FAIL illegal_store_u err=%b wr_en=%0d lat=%0d want 1/0/1", e, nw, lat); end
    do_req(1'b1, 1'b1, MASK_W, 32'h10, 32'h0, 5'd14, lat, d, e, r, nr, nw);
    total++; if (e !== 1'b1 || d !== 32'h0 || nr + nw != 0) begin bad++; $display("FAIL illegal_both err=%b data=%h en=%0d want 1/0/0", e, d, nr + nw); end
  endtask

  task automatic test_back_to_back();
    int lat, nr, nw; logic [31:0] d; logic e; logic [4:0] r;
    longint t0;
    do_req(1'b1, 1'b0, MASK_W, 32'h10, 32'h0, 5'd1, lat, d, e, r, nr, nw);
    t0 = acc_time;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL ready_in_resp got=%b want=0", bus.req_ready); end
    do_req(1'b1, 1'b0, MASK_W, 32'h11, 32'h0, 5'd2, lat, d, e, r, nr, nw);
    total++; if ((acc_time - t0) / 10 != 3) begin bad++; $display("FAIL b2b_aligned period=%0d want=3", (acc_time - t0) / 10); end
    t0 = acc_time;
    do_req(1'b1, 1'b0, MASK_B, 32'h11, 32'h0, 5'd3, lat, d, e, r, nr, nw);
    total++; if ((acc_time - t0) / 10 != 6) begin bad++; $display("FAIL b2b_split period=%0d want=6", (acc_time - t0) / 10); end
    @(posedge clk); #1;
    total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL after_resp valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_busy_ignored();
    int got = -1; int extra = 0;
    logic [4:0] tag = 5'h0;
    @(negedge clk);
    for (int w = 0; w < 20 && !bus.req_ready; w++) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_load = 1'b0; bus.req_is_store = 1'b1;
    bus.req_funct3 = MASK_W; bus.req_addr = 32'h40; bus.req_wdata = 32'h12345678; bus.req_rd = 5'd7;
    @(posedge clk); #1;
    bus.req_addr = 32'h44; bus.req_wdata = 32'hCAFEF00D; bus.req_rd = 5'd9;
    for (int c = 1; c <= 10; c++) begin
      if (bus.resp_valid) begin got = c; tag = bus.resp_rd; break; end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    ref_store(32'h40, MASK_W, 32'h12345678);
    total++; if (got != 2 || tag !== 5'd7) begin bad++; $display("FAIL busy_resp lat=%0d tag=%0d want 2/7", got, tag); end
    repeat (4) begin @(posedge clk); #1; if (bus.resp_valid) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL busy_extra_resp got=%0d want=0", extra); end
    total++; if ({mem[8'h47], mem[8'h46], mem[8'h45], mem[8'h44]} !== {ref_mem[8'h47], ref_mem[8'h46], ref_mem[8'h45], ref_mem[8'h44]}) begin
      bad++; $display("FAIL busy_mem44 got=%h want=%h", {mem[8'h47], mem[8'h46], mem[8'h45], mem[8'h44]}, {ref_mem[8'h47], ref_mem[8'h46], ref_mem[8'h45], ref_mem[8'h44]});
    end
  endtask

  task automatic test_reset_mid();
    int lat, nr, nw, extra; logic [31:0] d; logic e; logic [4:0] r;
    do_req(1'b0, 1'b1, MASK_W, 32'h20, 32'h0, 5'd1, lat, d, e, r, nr, nw);
    do_req(1'b0, 1'b1, MASK_W, 32'h24, 32'h0, 5'd1, lat, d, e, r, nr, nw);
    @(negedge clk);
    for (int w = 0; w < 20 && !bus.req_ready; w++) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_load = 1'b0; bus.req_is_store = 1'b1;
    bus.req_funct3 = MASK_W; bus.req_addr = 32'h21; bus.req_wdata = 32'h11223344; bus.req_rd = 5'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.resp_valid, bus.resp_err, bus.mem_rd_en, bus.mem_wr_en, bus.resp_data, bus.resp_rd,
                  bus.mem_addr, bus.mem_wdata, bus.mem_mask} !== '0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_outputs wr_en=%b addr=%h ready=%b want 0/0/1", bus.mem_wr_en, bus.mem_addr, bus.req_ready);
    end
    ref_mem[8'h21] = 8'h44; ref_mem[8'h22] = 8'h33;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.resp_valid) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL midreset_resp got=%0d want=0", extra); end
    total++; if ({mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]} !== 32'h00003344) begin
      bad++; $display("FAIL midreset_mem got=%h want=00003344", {mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]});
    end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", bus.req_ready); end
  endtask

  task automatic test_random();
    logic [2:0] ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int lat, nr, nw, sel, n, acc, exp_lat;
    logic [31:0] d, a, wd, exp_data;
    logic e, ld, st, ill, mis, ok;
    logic [2:0] f3;
    logic [4:0] r, tag;
    for (int it = 0; it < 80; it++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        ld = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      end else if (sel < 6) begin
        ld = 1'b1; st = 1'b0; f3 = ld_codes[$urandom_range(0, 4)];
      end else begin
        ld = 1'b0; st = 1'b1; f3 = 3'($urandom_range(0, 2));
      end
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a = a | 32'hFFFFFF00;
      wd  = $urandom;
      tag = 5'($urandom_range(0, 31));
      ill = ref_illegal(ld, st, f3);
      n   = ref_size(f3);
      mis = !ill && ((a & 32'(n - 1)) != 0);
      acc = ill ? 0 : (mis ? n : 1);
      exp_lat  = ill ? 1 : (mis ? n + 1 : 2);
      exp_data = (!ill && ld) ? ref_load(a, f3) : 32'h0;
      do_req(ld, st, f3, a, wd, tag, lat, d, e, r, nr, nw);
      total++; if (d !== exp_data || e !== ill || r !== tag) begin
        bad++; $display("FAIL rand[%0d] resp data=%h err=%b tag=%0d want %h/%b/%0d (ld=%b st=%b f3=%b a=%h)", it, d, e, r, exp_data, ill, tag, ld, st, f3, a);
      end
      total++; if (lat != exp_lat) begin bad++; $display("FAIL rand[%0d] lat got=%0d want=%0d", it, lat, exp_lat); end
      total++; if (nr != (ld ? acc : 0) || nw != (ld ? 0 : acc)) begin
        bad++; $display("FAIL rand[%0d] enables rd=%0d wr=%0d want access count %0d", it, nr, nw, acc);
      end
      ok = (seen_addr.size() == acc);
      for (int k = 0; k < seen_addr.size() && ok; k++) if (seen_addr[k] !== a + 32'(k)) ok = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL rand[%0d] addrs count=%0d want %0d from %h", it, seen_addr.size(), acc, a); end
    end
    ok = 1'b1;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) ok = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL rand_mem_image differs from reference image"); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_extend();
    test_split_load();
    test_split_store();
    test_illegal();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
